// File: rtl/truth_table_sweeper.sv
// Walks all 2^N input vectors of a combinational function, samples y_in after SETTLE
// cycles per vector and builds/checks its truth table. Define SWEEP_GRAY_EN for Gray-order sweeps.
module truth_table_sweeper #(
    parameter int N = 4,
    parameter int SETTLE = 1,
    parameter logic [(1<<N)-1:0] EXPECT = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                y_in,
    output logic [N-1:0]        vec,
    output logic                busy,
    output logic                done,
    output logic [(1<<N)-1:0]   tt,
    output logic [N:0]          ones,
    output logic                mismatch,
    output logic [N-1:0]        first_bad
);

    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int OW = N + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  step;
    logic [WW-1:0] wait_cnt;

    // Sweep-order to vector mapping; tt is indexed by vector value so it is order-independent.
    function automatic logic [N-1:0] seq(input logic [N-1:0] i);
`ifdef SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            wait_cnt  <= '0;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tt        <= '0;
            ones      <= '0;
            mismatch  <= 1'b0;
            first_bad <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tt        <= '0;
                        ones      <= '0;
                        mismatch  <= 1'b0;
                        first_bad <= '0;
                        step      <= '0;
                        wait_cnt  <= '0;
                        vec       <= seq('0);
                        busy      <= 1'b1;
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (wait_cnt != WW'(SETTLE - 1)) begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end else begin
                        // Final edge of the settle window: capture this row.
                        tt[vec] <= y_in;
                        ones    <= ones + OW'(y_in);
                        if ((y_in != EXPECT[vec]) && !mismatch) begin
                            mismatch  <= 1'b1;
                            first_bad <= vec;
                        end
                        if (&step) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            step     <= step + N'(1);
                            vec      <= seq(step + N'(1));
                            wait_cnt <= '0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two N=4 instances (SETTLE=1 and SETTLE=3 with a
// 2-cycle delayed function) checked against a table-based reference model.
module tb_truth_table_sweeper;

    localparam logic [15:0] EXP_A = 16'h8888;
    localparam logic [15:0] EXP_B = 16'hFF00;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic        y_in_a, y_in_b;
    logic [3:0]  vec_a, vec_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [15:0] tt_a, tt_b;
    logic [4:0]  ones_a, ones_b;
    logic        mismatch_a, mismatch_b;
    logic [3:0]  first_bad_a, first_bad_b;

    logic [15:0] fn_a, fn_b;
    logic        d1_b, d2_b;

    int compared = 0;
    int mismatched = 0;

    truth_table_sweeper #(.N(4), .SETTLE(1), .EXPECT(EXP_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .y_in(y_in_a),
        .vec(vec_a), .busy(busy_a), .done(done_a), .tt(tt_a),
        .ones(ones_a), .mismatch(mismatch_a), .first_bad(first_bad_a)
    );

    truth_table_sweeper #(.N(4), .SETTLE(3), .EXPECT(EXP_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .y_in(y_in_b),
        .vec(vec_b), .busy(busy_b), .done(done_b), .tt(tt_b),
        .ones(ones_b), .mismatch(mismatch_b), .first_bad(first_bad_b)
    );

    // Clock and function-under-test models
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign y_in_a = fn_a[vec_a];

    always @(posedge clk) begin
        d1_b <= fn_b[vec_b];
        d2_b <= d1_b;
    end
    assign y_in_b = d2_b;

    // Reference model helpers
    function automatic logic [3:0] tb_seq(input int i);
        int g;
`ifdef SWEEP_GRAY_EN
        g = i ^ (i >> 1);
`else
        g = i;
`endif
        return g[3:0];
    endfunction

    function automatic logic [3:0] model_first_bad(input logic [15:0] fn, input logic [15:0] exp);
        logic [3:0] v;
        for (int i = 0; i < 16; i++) begin
            v = tb_seq(i);
            if (fn[v] != exp[v]) return v;
        end
        return 4'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit which, input logic val);
        if (which) start_b = val;
        else start_a = val;
    endtask

    // Driver: called at a negedge; pulses start and follows the whole sweep cycle by cycle.
    task automatic run_sweep(input bit which, input logic [15:0] fn, input int inj);
        int s;
        int total;
        logic [15:0] exp;
        logic [3:0] v;
        logic b, d, mm;
        logic [15:0] t;
        logic [4:0] o;
        logic [3:0] fb;
        s = which ? 3 : 1;
        total = 16 * s;
        exp = which ? EXP_B : EXP_A;
        if (which) fn_b = fn;
        else fn_a = fn;
        set_start(which, 1'b1);
        for (int c = 0; c <= total + 2; c++) begin
            @(negedge clk);
            set_start(which, (c == inj || c == total) ? 1'b1 : 1'b0);
            v  = which ? vec_b : vec_a;
            b  = which ? busy_b : busy_a;
            d  = which ? done_b : done_a;
            check($sformatf("busy[%0d] c=%0d", which, c), 32'(b), 32'(c < total));
            check($sformatf("done[%0d] c=%0d", which, c), 32'(d), 32'(c == total + 1));
            check($sformatf("vec[%0d] c=%0d", which, c), 32'(v),
                  32'(tb_seq((c < total) ? (c / s) : 15)));
            if (c == total + 1 || c == total + 2) begin
                t  = which ? tt_b : tt_a;
                o  = which ? ones_b : ones_a;
                mm = which ? mismatch_b : mismatch_a;
                fb = which ? first_bad_b : first_bad_a;
                check($sformatf("tt[%0d] c=%0d", which, c), 32'(t), 32'(fn));
                check($sformatf("ones[%0d] c=%0d", which, c), 32'(o), 32'($countones(fn)));
                check($sformatf("mismatch[%0d] c=%0d", which, c), 32'(mm), 32'(fn != exp));
                if (fn != exp)
                    check($sformatf("first_bad[%0d] c=%0d", which, c), 32'(fb),
                          32'(model_first_bad(fn, exp)));
            end
        end
        set_start(which, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " vec_a"}, 32'(vec_a), 0);
        check({tag, " busy_a"}, 32'(busy_a), 0);
        check({tag, " done_a"}, 32'(done_a), 0);
        check({tag, " tt_a"}, 32'(tt_a), 0);
        check({tag, " ones_a"}, 32'(ones_a), 0);
        check({tag, " mismatch_a"}, 32'(mismatch_a), 0);
        check({tag, " first_bad_a"}, 32'(first_bad_a), 0);
        check({tag, " vec_b"}, 32'(vec_b), 0);
        check({tag, " busy_b"}, 32'(busy_b), 0);
        check({tag, " tt_b"}, 32'(tt_b), 0);
        check({tag, " ones_b"}, 32'(ones_b), 0);
        check({tag, " mismatch_b"}, 32'(mismatch_b), 0);
        check({tag, " first_bad_b"}, 32'(first_bad_b), 0);
    endtask

    // Abort a sweep at step 6 with an asynchronous reset between clock edges.
    task automatic reset_mid(input bit which, input logic [15:0] fn);
        int s;
        s = which ? 3 : 1;
        if (which) fn_b = fn;
        else fn_a = fn;
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        repeat (6 * s) @(negedge clk);
        check($sformatf("pre-reset busy[%0d]", which), 32'(which ? busy_b : busy_a), 1);
        #2 rst = 1'b1;
        #1 check_all_zero("mid-reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        fn_a = '0;
        fn_b = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_sweep(1'b0, 16'h0000, 5);
        run_sweep(1'b0, 16'h8888, 9);
        run_sweep(1'b0, 16'h000C, 3);
        for (int k = 0; k < 4; k++)
            run_sweep(1'b0, 16'($urandom), int'($urandom_range(1, 15)));

        run_sweep(1'b1, 16'hFF00, 20);
        for (int k = 0; k < 2; k++)
            run_sweep(1'b1, 16'($urandom), int'($urandom_range(1, 47)));

        reset_mid(1'b0, 16'hFFFF);
        run_sweep(1'b0, 16'($urandom), int'($urandom_range(1, 15)));
        reset_mid(1'b1, 16'hFFFF);
        run_sweep(1'b1, 16'($urandom), int'($urandom_range(1, 47)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
